// File: rtl/ahb_burst_tester.sv
// AHB-Lite traffic master for SRAM bring-up: writes a seed+i pattern to a word block,
// reads it back, compares each word and reports the error count and first failing address.
module ahb_burst_tester #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned MAX_WORDS_W = 10,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic                   burst_en,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [MAX_WORDS_W-1:0] num_words,
  input  logic [DATA_W-1:0]      seed,
  output logic                   hsel,
  output logic                   hwrite,
  output logic [1:0]             htrans,
  output logic [2:0]             hsize,
  output logic [2:0]             hburst,
  output logic [ADDR_W-1:0]      haddr,
  output logic [DATA_W-1:0]      hwdata,
  output logic                   hready,
  input  logic                   hready_resp,
  input  logic [1:0]             hresp,
  input  logic [DATA_W-1:0]      hrdata,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_CNT_W-1:0]   err_cnt,
  output logic [ADDR_W-1:0]      first_err_addr
);

  localparam int unsigned BYTES   = DATA_W / 8;
  localparam int unsigned STEP_SH = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(BYTES - 1);
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_TAIL, S_RD, S_RD_TAIL, S_FIN
  } state_t;

  state_t state_q, state_nxt;

  logic [MAX_WORDS_W-1:0] idx_q, idx_nxt, last_q;
  logic                   rd_pass_q, burst_q;
  logic [ADDR_W-1:0]      base_q;
  logic [DATA_W-1:0]      seed_q;
  logic                   d_valid_q, d_write_q;
  logic [ADDR_W-1:0]      d_addr_q;
  logic [DATA_W-1:0]      d_pat_q;

  logic                   accept;
  logic [ADDR_W-1:0]      base_e;
  logic                   burst_e, rd_pass_e;
  logic                   addr_act_nxt, hwrite_nxt;
  logic [1:0]             htrans_nxt;
  logic [ADDR_W-1:0]      haddr_nxt;
  logic [DATA_W-1:0]      pat_cur;
  logic                   hit_err;
  logic [ERR_CNT_W-1:0]   err_nxt;

  assign hready = 1'b1;
  assign accept = (state_q == S_IDLE) && start;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  // idx_q is the word whose address phase is on the bus; WR_TAIL may carry read word 0
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_nxt = '0;
          if (num_words == '0)    state_nxt = S_FIN;
          else if (mode == 2'b10) state_nxt = S_RD;
          else                    state_nxt = S_WR;
        end
      end
      S_WR: begin
        if (hready_resp) begin
          if (idx_q == last_q) begin
            state_nxt = S_WR_TAIL;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx_q + MAX_WORDS_W'(1);
          end
        end
      end
      S_WR_TAIL: begin
        if (hready_resp) begin
          if (!rd_pass_q)          state_nxt = S_FIN;
          else if (last_q == '0)   state_nxt = S_RD_TAIL;
          else begin
            state_nxt = S_RD;
            idx_nxt   = MAX_WORDS_W'(1);
          end
        end
      end
      S_RD: begin
        if (hready_resp) begin
          if (idx_q == last_q) state_nxt = S_RD_TAIL;
          else                 idx_nxt   = idx_q + MAX_WORDS_W'(1);
        end
      end
      S_RD_TAIL: if (hready_resp) state_nxt = S_FIN;
      S_FIN:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered bus and status outputs
  always_comb begin
    base_e       = accept ? (base_addr & ~LOW_MASK) : base_q;
    burst_e      = accept ? burst_en : burst_q;
    rd_pass_e    = accept ? (mode != 2'b01) : rd_pass_q;
    addr_act_nxt = (state_nxt == S_WR) || (state_nxt == S_RD) ||
                   ((state_nxt == S_WR_TAIL) && rd_pass_e);
    hwrite_nxt   = (state_nxt == S_WR);
    haddr_nxt    = haddr;
    htrans_nxt   = TR_IDLE;
    if (addr_act_nxt) begin
      haddr_nxt = base_e + (ADDR_W'(idx_nxt) << STEP_SH);
      if (!burst_e || (idx_nxt == '0) || (haddr_nxt[9:0] == 10'd0)) htrans_nxt = TR_NONSEQ;
      else                                                        htrans_nxt = TR_SEQ;
    end
    pat_cur = seed_q + DATA_W'(idx_q);
    hit_err = d_valid_q && hready_resp &&
              ((hresp != 2'b00) || (!d_write_q && (hrdata != d_pat_q)));
    err_nxt = err_cnt;
    if (accept)                        err_nxt = '0;
    else if (hit_err && err_cnt != '1) err_nxt = err_cnt + ERR_CNT_W'(1);
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      hsel           <= 1'b0;
      hwrite         <= 1'b0;
      htrans         <= TR_IDLE;
      hsize          <= 3'b000;
      hburst         <= 3'b000;
      haddr          <= '0;
      hwdata         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      idx_q          <= '0;
      last_q         <= '0;
      rd_pass_q      <= 1'b0;
      burst_q        <= 1'b0;
      base_q         <= '0;
      seed_q         <= '0;
      d_valid_q      <= 1'b0;
      d_write_q      <= 1'b0;
      d_addr_q       <= '0;
      d_pat_q        <= '0;
    end else begin
      hsel    <= addr_act_nxt;
      hwrite  <= hwrite_nxt;
      htrans  <= htrans_nxt;
      haddr   <= haddr_nxt;
      idx_q   <= idx_nxt;
      err_cnt <= err_nxt;
      busy    <= (state_nxt != S_IDLE) && (state_nxt != S_FIN);
      done    <= (state_nxt == S_FIN);
      if (accept) begin
        base_q    <= base_e;
        burst_q   <= burst_en;
        rd_pass_q <= rd_pass_e;
        seed_q    <= seed;
        last_q    <= num_words - MAX_WORDS_W'(1);
        hsize     <= 3'(STEP_SH);
        hburst    <= burst_en ? 3'b001 : 3'b000;
        pass      <= 1'b0;
      end
      // An accepted address phase becomes the data phase of the next cycle
      if (hready_resp) begin
        d_valid_q <= hsel;
        d_write_q <= hwrite;
        d_addr_q  <= haddr;
        d_pat_q   <= pat_cur;
        if (hsel && hwrite) hwdata <= pat_cur;
      end
      if (hit_err && (err_cnt == '0)) first_err_addr <= d_addr_q;
      if (state_nxt == S_FIN)         pass <= (err_nxt == '0);
    end
  end

endmodule

// File: tb/tb_ahb_burst_tester.sv
// Directed bench for ahb_burst_tester: SRAM-like slave with injectable stalls and read
// corruption, a bus monitor logging accepted transfers, and immediate-assert checks.
module tb_ahb_burst_tester;

  logic        hclk;
  logic        hreset;
  logic        start;
  logic [1:0]  mode;
  logic        burst_en;
  logic [31:0] base_addr;
  logic [9:0]  num_words;
  logic [31:0] seed;
  logic        hsel, hwrite, hready, hready_resp;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hsize, hburst;
  logic [31:0] haddr, hwdata, hrdata;
  logic        busy, done, pass;
  logic [7:0]  err_cnt;
  logic [31:0] first_err_addr;

  int checks = 0;
  int errors = 0;

  ahb_burst_tester #(
    .DATA_W(32), .ADDR_W(32), .MAX_WORDS_W(10), .ERR_CNT_W(8)
  ) dut (
    .hclk(hclk), .hreset(hreset), .start(start), .mode(mode), .burst_en(burst_en),
    .base_addr(base_addr), .num_words(num_words), .seed(seed),
    .hsel(hsel), .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hburst(hburst),
    .haddr(haddr), .hwdata(hwdata), .hready(hready),
    .hready_resp(hready_resp), .hresp(hresp), .hrdata(hrdata),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Slave: word memory, optional stall on the Nth write/read data phase, optional bad word
  logic [31:0] mem [0:2047];
  logic        dp_valid, dp_write;
  logic [10:0] dp_idx;
  int wait_cnt, wr_beats, rd_beats;
  int stall_wr_at = -1;
  int stall_rd_at = -1;
  int stall_len   = 0;
  int corrupt_idx = -1;

  assign hready_resp = (wait_cnt == 0);
  assign hresp       = 2'b00;
  assign hrdata      = (int'(dp_idx) == corrupt_idx) ? 32'h0000DEAD : mem[dp_idx];

  always @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      wait_cnt <= 0;
      wr_beats <= 0;
      rd_beats <= 0;
    end else begin
      if (wait_cnt != 0) begin
        wait_cnt <= wait_cnt - 1;
      end else begin
        if (dp_valid && dp_write) mem[dp_idx] <= hwdata;
        dp_valid <= hsel && htrans[1];
        dp_write <= hwrite;
        dp_idx   <= haddr[12:2];
        if (hsel && htrans[1]) begin
          if (hwrite) begin
            if (wr_beats == stall_wr_at) wait_cnt <= stall_len;
            wr_beats <= wr_beats + 1;
          end else begin
            if (rd_beats == stall_rd_at) wait_cnt <= stall_len;
            rd_beats <= rd_beats + 1;
          end
        end
      end
      if (!busy) begin
        wr_beats <= 0;
        rd_beats <= 0;
      end
    end
  end

  // Monitor: accepted address phases, completed write data, stall freeze tracking
  logic [31:0] la_addr  [$];
  logic [1:0]  la_trans [$];
  logic        la_write [$];
  logic [31:0] wd_log   [$];
  int          stall_cyc  = 0;
  int          freeze_bad = 0;
  logic        prev_low   = 1'b0;
  logic [67:0] snap;
  logic [67:0] bus_now;
  assign bus_now = {haddr, htrans, hwrite, hsel, hwdata};

  always @(negedge hclk) begin
    if (!hreset) begin
      if (hsel && htrans[1] && hready_resp) begin
        la_addr.push_back(haddr);
        la_trans.push_back(htrans);
        la_write.push_back(hwrite);
      end
      if (dp_valid && dp_write && hready_resp) wd_log.push_back(hwdata);
      if (prev_low && (bus_now != snap)) freeze_bad++;
      if (!hready_resp) stall_cyc++;
      prev_low = !hready_resp;
      snap     = bus_now;
    end else begin
      prev_low = 1'b0;
    end
  end

  localparam logic [31:0] EA1 [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h4, 32'h8, 32'hC};
  localparam logic [1:0]  ET1 [8] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11};
  localparam logic [31:0] EA4 [4] = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
  localparam logic [1:0]  ET4 [4] = '{2'b10, 2'b11, 2'b10, 2'b11};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start at a negedge, count cycles to done; optionally re-pulse start while busy
  task automatic run(input logic [1:0] m, input logic b, input logic [31:0] ba,
                     input logic [9:0] n, input logic [31:0] sd, input int poke,
                     output int cyc, output logic busy1);
    mode = m; burst_en = b; base_addr = ba; num_words = n; seed = sd; start = 1'b1;
    @(posedge hclk);
    @(negedge hclk);
    start = 1'b0;
    cyc   = 1;
    busy1 = busy;
    while (done !== 1'b1 && cyc < 200) begin
      if (cyc == poke) begin
        start = 1'b1; mode = 2'b01; base_addr = 32'h700; num_words = 10'd1;
      end
      @(negedge hclk);
      start = 1'b0;
      cyc++;
    end
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    @(negedge hclk);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    int   cyc, a0, w0, s0, f0;
    logic b1;
    hreset = 1'b1; start = 1'b0; mode = 2'b00; burst_en = 1'b0;
    base_addr = '0; num_words = '0; seed = '0;
    repeat (3) @(negedge hclk);
    chk("rst_htrans", 64'(htrans), 64'd0);
    chk("rst_hsel", 64'(hsel), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_err", 64'(err_cnt), 64'd0);
    chk("rst_haddr", 64'(haddr), 64'd0);
    chk("rst_hready", 64'(hready), 64'd1);
    hreset = 1'b0;
    @(negedge hclk);

    // Write+readback, INCR burst, zero waits
    a0 = la_addr.size(); w0 = wd_log.size();
    run(2'b00, 1'b1, 32'h0, 10'd4, 32'h123AF, -1, cyc, b1);
    chk("t1_cycles", 64'(cyc), 64'd10);
    chk("t1_busy_c1", 64'(b1), 64'd1);
    chk("t1_pass", 64'(pass), 64'd1);
    chk("t1_err", 64'(err_cnt), 64'd0);
    chk("t1_hburst", 64'(hburst), 64'd1);
    chk("t1_hsize", 64'(hsize), 64'd2);
    chk("t1_naddr", 64'(la_addr.size() - a0), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_addr%0d", i), 64'(la_addr[a0+i]), 64'(EA1[i]));
      chk($sformatf("t1_trans%0d", i), 64'(la_trans[a0+i]), 64'(ET1[i]));
      chk($sformatf("t1_write%0d", i), 64'(la_write[a0+i]), (i < 4) ? 64'd1 : 64'd0);
    end
    chk("t1_nwd", 64'(wd_log.size() - w0), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_wdata%0d", i), 64'(wd_log[w0+i]), 64'h123AF + 64'(i));

    // Same run with 3-cycle stalls on write beat 1 and read beat 2
    stall_wr_at = 1; stall_rd_at = 2; stall_len = 3;
    a0 = la_addr.size(); s0 = stall_cyc; f0 = freeze_bad;
    run(2'b00, 1'b1, 32'h0, 10'd4, 32'h123AF, -1, cyc, b1);
    stall_wr_at = -1; stall_rd_at = -1; stall_len = 0;
    chk("t2_cycles", 64'(cyc), 64'd16);
    chk("t2_pass", 64'(pass), 64'd1);
    chk("t2_stalls", 64'(stall_cyc - s0), 64'd6);
    chk("t2_frozen", 64'(freeze_bad - f0), 64'd0);
    chk("t2_naddr", 64'(la_addr.size() - a0), 64'd8);

    // Preload with write-only, then read-compare with word 2 corrupted
    a0 = la_addr.size();
    run(2'b01, 1'b1, 32'h100, 10'd4, 32'h55AA0000, -1, cyc, b1);
    chk("t3w_cycles", 64'(cyc), 64'd6);
    chk("t3w_naddr", 64'(la_addr.size() - a0), 64'd4);
    chk("t3w_last_write", 64'(la_write[a0+3]), 64'd1);
    chk("t3w_pass", 64'(pass), 64'd1);
    corrupt_idx = 66;
    a0 = la_addr.size();
    run(2'b10, 1'b1, 32'h100, 10'd4, 32'h55AA0000, -1, cyc, b1);
    corrupt_idx = -1;
    chk("t3r_cycles", 64'(cyc), 64'd6);
    chk("t3r_first_write", 64'(la_write[a0]), 64'd0);
    chk("t3r_err", 64'(err_cnt), 64'd1);
    chk("t3r_first_err", 64'(first_err_addr), 64'h108);
    chk("t3r_pass", 64'(pass), 64'd0);

    // Zero-length run: immediate done, no bus activity
    a0 = la_addr.size();
    run(2'b00, 1'b1, 32'h0, 10'd0, 32'h0, -1, cyc, b1);
    chk("t5_cycles", 64'(cyc), 64'd1);
    chk("t5_pass", 64'(pass), 64'd1);
    chk("t5_err", 64'(err_cnt), 64'd0);
    chk("t5_naddr", 64'(la_addr.size() - a0), 64'd0);

    // start re-pulsed while busy must be ignored
    a0 = la_addr.size();
    run(2'b00, 1'b1, 32'h80, 10'd4, 32'h1000, 3, cyc, b1);
    chk("t5b_cycles", 64'(cyc), 64'd10);
    chk("t5b_naddr", 64'(la_addr.size() - a0), 64'd8);
    chk("t5b_first", 64'(la_addr[a0]), 64'h80);
    chk("t5b_last", 64'(la_addr[a0+7]), 64'h8C);
    chk("t5b_pass", 64'(pass), 64'd1);

    // 1 KB crossing inside an INCR burst restarts with NONSEQ
    a0 = la_addr.size();
    run(2'b01, 1'b1, 32'h3F8, 10'd4, 32'h7, -1, cyc, b1);
    chk("t4_naddr", 64'(la_addr.size() - a0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_addr%0d", i), 64'(la_addr[a0+i]), 64'(EA4[i]));
      chk($sformatf("t4_trans%0d", i), 64'(la_trans[a0+i]), 64'(ET4[i]));
    end

    // Non-burst: all NONSEQ, hburst SINGLE, low address bits dropped
    a0 = la_addr.size();
    run(2'b01, 1'b0, 32'h201, 10'd2, 32'h9, -1, cyc, b1);
    chk("t4s_cycles", 64'(cyc), 64'd4);
    chk("t4s_hburst", 64'(hburst), 64'd0);
    chk("t4s_addr0", 64'(la_addr[a0]), 64'h200);
    chk("t4s_addr1", 64'(la_addr[a0+1]), 64'h204);
    chk("t4s_trans1", 64'(la_trans[a0+1]), 64'd2);

    // Asynchronous reset on the third write address phase
    mode = 2'b00; burst_en = 1'b1; base_addr = 32'h0; num_words = 10'd4; seed = 32'h42;
    start = 1'b1;
    @(posedge hclk);
    @(negedge hclk);
    start = 1'b0;
    @(negedge hclk);
    @(negedge hclk);
    chk("t6_pre_haddr", 64'(haddr), 64'h8);
    hreset = 1'b1;
    #1;
    chk("t6_htrans", 64'(htrans), 64'd0);
    chk("t6_hsel", 64'(hsel), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_hready", 64'(hready), 64'd1);
    @(negedge hclk);
    hreset = 1'b0;
    @(negedge hclk);
    a0 = la_addr.size(); w0 = wd_log.size();
    run(2'b00, 1'b0, 32'h20, 10'd2, 32'hABC, -1, cyc, b1);
    chk("t6_cycles", 64'(cyc), 64'd6);
    chk("t6_pass", 64'(pass), 64'd1);
    chk("t6_naddr", 64'(la_addr.size() - a0), 64'd4);
    chk("t6_wd0", 64'(wd_log[w0]), 64'hABC);
    chk("t6_wd1", 64'(wd_log[w0+1]), 64'hABD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_burst_tester.md
# ahb_burst_tester

Synthesizable AHB-Lite master that exercises the SRAM controller (`sramc_top`) without a behavioural bench. Per run it writes a deterministic pattern to a block of consecutive words, then reads the block back and compares each word. Results go to a small status interface. The design is parametrised in data width and maximum run length, supports single or INCR-burst transfers, and fully honours `hready_resp` wait states and `hresp`. It sits beside `sramc_top` in silicon bring-up and regression tops, driving the same `hsel`/`htrans`/`haddr` bus.

## Interface
- `DATA_W`, 32: data bus width, 32 or 64; `hsize` = log2(`DATA_W`/8), address step `DATA_W`/8 bytes.
- `ADDR_W`, 32: address width.
- `MAX_WORDS_W`, 10: width of `num_words`; max run = 2^`MAX_WORDS_W`-1 words.
- `ERR_CNT_W`, 8: error counter width, saturating.

Ports:
- `hclk` in 1: single clock for all logic.
- `hreset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; ignored while `busy`=1.
- `mode` in 2: 00 write+readback, 01 write only, 10 read+compare only, 11 reserved (treated as 00).
- `burst_en` in 1: 1 = INCR burst (NONSEQ then SEQ), 0 = every transfer SINGLE/NONSEQ.
- `base_addr` in `ADDR_W`: byte address of word 0, sampled on accepted `start`; low log2(`DATA_W`/8) bits ignored (forced 0).
- `num_words` in `MAX_WORDS_W`: words per run, sampled on `start`.
- `seed` in `DATA_W`: pattern seed, sampled on `start`.
- `hsel`, `hwrite` out 1; `htrans` out 2; `hsize`, `hburst` out 3; `haddr` out `ADDR_W`; `hwdata` out `DATA_W`: AHB master outputs.
- `hready` out 1: always 1 (this master is the only one on the bus).
- `hready_resp` in 1, `hresp` in 2, `hrdata` in `DATA_W`: slave response.
- `busy` out 1; `done` out 1 (one-cycle pulse); `pass` out 1; `err_cnt` out `ERR_CNT_W`; `first_err_addr` out `ADDR_W`.

## Operation
- Pattern for word i: `seed + i`, computed modulo 2^`DATA_W`. The address of word i is `base_addr + i*(DATA_W/8)`.
- The FSM has these states: IDLE, WR, WR_TAIL, RD, RD_TAIL, FIN.
  - IDLE: when `start`=1, latch the inputs and set `busy`. Go to WR, or RD if mode=10. If `num_words`=0, go directly to FIN.
  - WR: drive the address phase for word i. Advance i only when `hready_resp`=1. After the last address phase is accepted, go to WR_TAIL.
  - WR_TAIL: this is the last data phase. Hold `hwdata` until `hready_resp`=1, then go to RD (mode 00) or FIN (mode 01).
  - RD / RD_TAIL: the same pipeline as WR / WR_TAIL. In each data phase completed with `hready_resp`=1, compare `hrdata` with the pattern.
  - FIN: pulse `done` for 1 cycle, clear `busy`, return to IDLE.
- Pipelining: the address phase of word i+1 overlaps the data phase of word i. `hwdata` for word i is driven in the cycle after its address phase is accepted. No idle cycle is inserted between the write and read passes; the first read NONSEQ overlaps the last write data phase.
- Bursts (`burst_en`=1): `hburst`=001 (INCR). The first beat is NONSEQ and later beats are SEQ. A beat whose address crosses a 1 KB boundary (`haddr[9:0]`==0, i≠0) is issued as NONSEQ. With `burst_en`=0, `hburst`=000 and every beat is NONSEQ.
- Outside WR/RD address phases: `htrans`=IDLE (00), `hsel`=0, `hwrite`=0, `haddr` holds its last value.
- Error counting: a data phase completing with `hresp`≠00 is an error, as is a read-data mismatch. Each increments `err_cnt`, which saturates at all-ones. The first error of a run latches its word address into `first_err_addr`. The run continues after an error; there is no abort.
- `pass` = (`err_cnt`==0), updated in FIN. `err_cnt`, `first_err_addr` and `pass` hold until the next accepted `start`, which clears `err_cnt` and `pass`.
- Reset (any cycle, including mid-burst): all outputs zero, `htrans`=IDLE, state IDLE, `busy`=0, `pass`=0. `hready` is 1 after reset as well.

## Timing
- `start` is sampled at posedge N. The first address phase (NONSEQ) is visible from posedge N+1.
- A run with zero wait states lasts 2·`num_words`+2 cycles from `start` to `done` in mode 00. In mode 01/10 it lasts `num_words`+2 cycles.
- While `hready_resp`=0, `haddr`, `htrans`, `hwrite` and `hwdata` are held stable and no counter advances.
- `done` is asserted in the cycle after the final data phase completes. `busy` falls in the same cycle as `done`.

## Test plan
- Mode 00, base 0x0, 4 words, seed 0x123AF, `burst_en`=1, zero waits. Required: writes of 0x123AF..0x123B2 to 0x0/0x4/0x8/0xC as NONSEQ,SEQ,SEQ,SEQ, then an identical read sequence; `done` at cycle 10; `pass`=1; `err_cnt`=0.
- Same run with `hready_resp` low for 3 cycles on the second write data phase and the third read data phase. Required: bus outputs frozen during each stall, `done` at cycle 16, `pass`=1.
- Mode 10 over memory preloaded with the pattern except word 2 corrupted to 0xDEAD. Required: `err_cnt`=1, `first_err_addr`=base+8, `pass`=0.
- INCR burst at base 0x3F8, 4 words. Required: NONSEQ at 0x3F8, SEQ at 0x3FC, NONSEQ at 0x400, SEQ at 0x404.
- `num_words`=0 → `done` pulse at N+1, `pass`=1, no bus activity. `start` pulsed while `busy` → ignored.
- Assert `hreset` during the third write beat. Required: `htrans`=IDLE, `hsel`=0, `busy`=0 asynchronously; the next `start` completes a normal run.
